// File: rtl/pipe_hazard_controller_pkg.sv
// pipe_hazard_controller_pkg: shared widths, defaults and memory FSM encoding for the hazard controller
package pipe_hazard_controller_pkg;
    localparam int REGFILE_ADDRESS_LEN = 4;
    localparam int DEFAULT_CNT_W = 2;
    localparam int DEFAULT_MEM_TIMEOUT = 63;
    typedef enum logic {MEM_IDLE = 1'b0, MEM_BUSY = 1'b1} mem_state_t;
endpackage

// File: rtl/pipe_hazard_controller_reg_scoreboard.sv
// reg_scoreboard: per-register pending-writer counters with issue/retire update and two pending lookups
module reg_scoreboard
    import pipe_hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W = REGFILE_ADDRESS_LEN,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue,
    input  logic [REG_ADDR_W-1:0] issue_dest,
    input  logic                  retire,
    input  logic [REG_ADDR_W-1:0] retire_dest,
    input  logic [REG_ADDR_W-1:0] rd_addr1,
    input  logic [REG_ADDR_W-1:0] rd_addr2,
    output logic                  pend1,
    output logic                  pend2,
    output logic                  sb_error
);
    localparam int N = 2 ** REG_ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0] cnt [N];
    logic [CNT_W-1:0] cnt_nxt [N];
    logic [N-1:0] inc;
    logic [N-1:0] dec;
    logic err_now;
    // A retiring write is visible through the register file this cycle, so it no longer blocks readers
    assign pend1 = (cnt[rd_addr1] != '0) && !(retire && retire_dest == rd_addr1);
    assign pend2 = (cnt[rd_addr2] != '0) && !(retire && retire_dest == rd_addr2);
    // Next count per register; simultaneous issue and retire on one register cancel out
    always_comb begin
        err_now = 1'b0;
        for (int i = 0; i < N; i++) begin
            inc[i] = issue && issue_dest == REG_ADDR_W'(i);
            dec[i] = retire && retire_dest == REG_ADDR_W'(i);
            cnt_nxt[i] = cnt[i];
            if (inc[i] && !dec[i]) begin
                if (cnt[i] == CNT_MAX) err_now = 1'b1;
                else cnt_nxt[i] = cnt[i] + 1'b1;
            end else if (dec[i] && !inc[i]) begin
                if (cnt[i] == '0) err_now = 1'b1;
                else cnt_nxt[i] = cnt[i] - 1'b1;
            end
        end
    end
    // Counter array and sticky overflow/underflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '{default: '0};
            sb_error <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (err_now) sb_error <= 1'b1;
        end
    end
endmodule

// File: rtl/pipe_hazard_controller.sv
// pipe_hazard_controller: stall/flush/freeze arbitration and SRAM wait sequencing for the 5-stage pipeline
module pipe_hazard_controller
    import pipe_hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W = REGFILE_ADDRESS_LEN,
    parameter int CNT_W = DEFAULT_CNT_W,
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_wb_en,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic                  wb_en,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  hazard,
    output logic                  hold_pc,
    output logic                  hold_ifid,
    output logic                  flush_ifid,
    output logic                  bubble_idex,
    output logic                  freeze,
    output logic                  sb_error,
    output logic                  mem_timeout
);
    localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);
    mem_state_t state;
    logic [TMR_W-1:0] timer;
    logic mem_wait;
    logic issue;
    logic retire;
    logic pend1;
    logic pend2;
    // A same-cycle ready completes the access without any wait cycle
    assign mem_wait = (state == MEM_BUSY) ? !mem_ready : (mem_req && !mem_ready);
    assign retire = wb_en && !mem_wait;
    assign hazard = id_valid && (pend1 || (id_two_src && pend2));
    assign issue = id_valid && id_wb_en && !hazard && !mem_wait && !branch_taken;
    assign freeze = mem_wait;
    assign hold_pc = mem_wait || (hazard && !branch_taken);
    assign hold_ifid = hold_pc;
    assign flush_ifid = !mem_wait && branch_taken;
    assign bubble_idex = !mem_wait && (branch_taken || hazard);
    reg_scoreboard #(.REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) u_sb (
        .clk(clk),
        .rst(rst),
        .issue(issue),
        .issue_dest(id_dest),
        .retire(retire),
        .retire_dest(wb_dest),
        .rd_addr1(id_src1),
        .rd_addr2(id_src2),
        .pend1(pend1),
        .pend2(pend2),
        .sb_error(sb_error)
    );
    // SRAM wait sequencer with a bounded busy period and sticky timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MEM_IDLE;
            timer <= '0;
            mem_timeout <= 1'b0;
        end else if (state == MEM_IDLE) begin
            timer <= '0;
            if (mem_req && !mem_ready) state <= MEM_BUSY;
        end else if (mem_ready) begin
            state <= MEM_IDLE;
            timer <= '0;
        end else if (timer == TMR_W'(MEM_TIMEOUT)) begin
            state <= MEM_IDLE;
            timer <= '0;
            mem_timeout <= 1'b1;
        end else begin
            timer <= timer + 1'b1;
        end
    end
endmodule
